// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 selector.
// The granted input is registered onto Mout, and a hold counter bounds how long one grant can last.
module rr_mux_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [1:0]       addr,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] Mout,
  output logic             valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               r_state, w_state;
  logic [1:0]           r_last, w_last;
  logic [HW-1:0]        r_hold, w_hold;
  logic [3:0]           r_gnt, w_gnt;
  logic [1:0]           r_addr, w_addr;
  logic [WIDTH-1:0]     r_mout, w_mout;
  logic                 r_valid, w_valid;

  logic [3:0][WIDTH-1:0] w_in;
  logic [3:0]            w_others;
  logic                  w_release;
  logic [2:0]            w_pick_idle, w_pick_rel;

  // Returns {found, index} of the first set bit scanning cyclically from start.
  function automatic logic [2:0] f_pick(input logic [3:0] rq, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (rq[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_in        = {in4, in3, in2, in1};
  assign w_others    = req & ~r_gnt;
  assign w_release   = !req[r_addr] || ((r_hold == HOLD_MAX) && (|w_others));
  assign w_pick_idle = f_pick(req, r_last + 2'd1);
  assign w_pick_rel  = f_pick(w_others, r_addr + 2'd1);

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_hold  = r_hold;
    w_gnt   = r_gnt;
    w_addr  = r_addr;
    w_mout  = r_mout;
    w_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt = '0;
        if (|req) begin
          w_gnt   = 4'b0001 << w_pick_idle[1:0];
          w_addr  = w_pick_idle[1:0];
          w_hold  = '0;
          w_state = GRANT;
        end
      end
      GRANT: begin
        // The owning requester's cycle is always captured, even on its release edge.
        w_mout  = w_in[r_addr];
        w_valid = 1'b1;
        if (w_release) begin
          w_last = r_addr;
          if (w_pick_rel[2]) begin
            w_gnt  = 4'b0001 << w_pick_rel[1:0];
            w_addr = w_pick_rel[1:0];
            w_hold = '0;
          end else begin
            w_gnt   = '0;
            w_state = IDLE;
          end
        end else if (r_hold != HOLD_MAX) begin
          w_hold = r_hold + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_addr  <= '0;
      r_mout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_hold  <= w_hold;
      r_gnt   <= w_gnt;
      r_addr  <= w_addr;
      r_mout  <= w_mout;
      r_valid <= w_valid;
    end
  end

  assign addr  = r_addr;
  assign gnt   = r_gnt;
  assign Mout  = r_mout;
  assign valid = r_valid;

endmodule
